// File: rtl/inject_arbiter.sv
// Round-robin injection arbiter: four requesters share one credit-flow-controlled
// router local input port, with a one-cycle registered output stage.
module inject_arbiter #(
    parameter int unsigned CREDITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] flit0,
    input  logic [19:0] flit1,
    input  logic [19:0] flit2,
    input  logic [19:0] flit3,
    input  logic        valid0,
    input  logic        valid1,
    input  logic        valid2,
    input  logic        valid3,
    output logic        ready0,
    output logic        ready1,
    output logic        ready2,
    output logic        ready3,
    input  logic        ci,
    output logic [19:0] dataout,
    output logic        out_valid,
    output logic [2:0]  credit_count,
    output logic [1:0]  state,
    output logic [15:0] sent_count,
    output logic        credit_err
);

    localparam int unsigned FLIT_W = 20;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned NREQ   = 4;
    localparam int unsigned SENT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [PTR_W-1:0]   ptr;
    logic [NREQ-1:0]    valid_vec;
    logic [NREQ-1:0]    grant;
    logic [PTR_W-1:0]   win;
    logic [PTR_W-1:0]   idx;
    logic               accept;
    logic [FLIT_W-1:0]  win_flit;
    logic [CNT_W-1:0]   credit_d;
    logic               err_set;

    assign valid_vec = {valid3, valid2, valid1, valid0};
    assign state     = state_q;

    // Round-robin search from ptr; gated by live credits and reset.
    always_comb begin
        accept = 1'b0;
        win    = '0;
        idx    = '0;
        if (!rst && credit_count != '0) begin
            for (int k = 0; k < int'(NREQ); k++) begin
                idx = ptr + PTR_W'(k);
                if (!accept && valid_vec[idx]) begin
                    accept = 1'b1;
                    win    = idx;
                end
            end
        end
        grant = accept ? (NREQ'(1) << win) : '0;
    end

    assign ready0 = grant[0];
    assign ready1 = grant[1];
    assign ready2 = grant[2];
    assign ready3 = grant[3];

    always_comb begin
        win_flit = flit0;
        case (win)
            2'd1:    win_flit = flit1;
            2'd2:    win_flit = flit2;
            2'd3:    win_flit = flit3;
            default: win_flit = flit0;
        endcase
    end

    // Credit bookkeeping: simultaneous send and return cancel; returns saturate at full.
    always_comb begin
        credit_d = credit_count;
        err_set  = 1'b0;
        case ({accept, ci})
            2'b10: credit_d = credit_count - CNT_W'(1);
            2'b01: begin
                if (credit_count == CNT_W'(CREDITS)) begin
                    err_set = 1'b1;
                end else begin
                    credit_d = credit_count + CNT_W'(1);
                end
            end
            default: credit_d = credit_count;
        endcase
    end

    // Next state reflects this cycle's demand and credit availability.
    always_comb begin
        state_d = IDLE;
        if (|valid_vec) begin
            state_d = (credit_count != '0) ? SEND : STALL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr          <= '0;
            dataout      <= '0;
            out_valid    <= 1'b0;
            credit_count <= CNT_W'(CREDITS);
            sent_count   <= '0;
            credit_err   <= 1'b0;
        end else begin
            out_valid    <= accept;
            credit_count <= credit_d;
            if (err_set) begin
                credit_err <= 1'b1;
            end
            if (accept) begin
                ptr        <= win + PTR_W'(1);
                dataout    <= win_flit;
                sent_count <= sent_count + SENT_W'(1);
            end
        end
    end

endmodule
